// File: rtl/seg_scan_ctl.sv
// Multiplexed 7-segment scan controller with frame snapshot, LZ blanking, blink and PWM dimming.
// Latency: seg_d/seg_com follow idx by 2 clocks; frame_done is aligned with idx. No backpressure.
module seg_scan_ctl #(
    parameter int NDIG       = 8,
    parameter int PRESC_W    = 16,
    parameter int BLINK_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          rate,
    input  logic [4*NDIG-1:0]   bcd,
    input  logic [NDIG-1:0]     dp_mask,
    input  logic [NDIG-1:0]     blink_mask,
    input  logic                blank_lz,
    input  logic                hex_mode,
    input  logic [3:0]          bright,
    output logic [7:0]          seg_d,
    output logic [NDIG-1:0]     seg_com,
    output logic                frame_done
);
    localparam int IDX_W = $clog2(NDIG);
    // one extra bit so the MSB toggles every 2^BLINK_LOG2 frames
    localparam int BC_W  = BLINK_LOG2 + 1;

    logic [PRESC_W-1:0] pcnt_q, pcnt_d, rate_mask;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         pwm_q, pwm_d;
    logic [BC_W-1:0]    bcnt_q, bcnt_d;
    logic [4*NDIG-1:0]  sh_bcd_q, sh_bcd_d;
    logic [NDIG-1:0]    sh_dp_q, sh_dp_d, sh_bl_q, sh_bl_d;
    logic               fd_q, fd_d;
    logic [3:0]         s1_nib_q, s1_nib_d;
    logic               s1_dp_q, s1_dp_d, s1_lz_q, s1_lz_d, s1_bk_q, s1_bk_d;
    logic [NDIG-1:0]    s1_com_q, s1_com_d;
    logic [7:0]         seg_d_q, seg_d_d;
    logic [NDIG-1:0]    seg_com_q, seg_com_d;
    logic               tick, wrap;
    logic [6:0]         glyph;

    always_comb begin
        rate_mask = (PRESC_W'(1) << rate) - PRESC_W'(1);
        tick      = (pcnt_q & rate_mask) == rate_mask;
        wrap      = tick && (idx_q == IDX_W'(NDIG - 1));

        pcnt_d   = pcnt_q + PRESC_W'(1);
        pwm_d    = pwm_q + 4'd1;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        sh_bcd_d = sh_bcd_q;
        sh_dp_d  = sh_dp_q;
        sh_bl_d  = sh_bl_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        if (wrap) begin
            bcnt_d   = bcnt_q + BC_W'(1);
            sh_bcd_d = bcd;
            sh_dp_d  = dp_mask;
            sh_bl_d  = blink_mask;
        end
        fd_d = wrap;

        // stage 1: per-digit attributes from the shadow copy only
        s1_nib_d = sh_bcd_q[{idx_q, 2'b00} +: 4];
        s1_dp_d  = sh_dp_q[idx_q];
        s1_lz_d  = blank_lz && (idx_q != '0) && ((sh_bcd_q >> {idx_q, 2'b00}) == '0);
        s1_bk_d  = bcnt_q[BC_W-1] && sh_bl_q[idx_q];
        s1_com_d = NDIG'(1) << idx_q;

        // stage 2: glyph decode, blanking and PWM gating of the common
        glyph = 7'h00;
        case (s1_nib_q)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h27;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = hex_mode ? 7'h77 : 7'h00;
            4'hB: glyph = hex_mode ? 7'h7C : 7'h00;
            4'hC: glyph = hex_mode ? 7'h39 : 7'h00;
            4'hD: glyph = hex_mode ? 7'h5E : 7'h00;
            4'hE: glyph = hex_mode ? 7'h79 : 7'h00;
            default: glyph = hex_mode ? 7'h71 : 7'h00;
        endcase
        seg_d_d   = s1_bk_q ? 8'h00 : {s1_dp_q, (s1_lz_q ? 7'h00 : glyph)};
        seg_com_d = (pwm_q <= bright) ? s1_com_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q    <= '0;
            idx_q     <= '0;
            pwm_q     <= '0;
            bcnt_q    <= '0;
            sh_bcd_q  <= '0;
            sh_dp_q   <= '0;
            sh_bl_q   <= '0;
            fd_q      <= 1'b0;
            s1_nib_q  <= '0;
            s1_dp_q   <= 1'b0;
            s1_lz_q   <= 1'b0;
            s1_bk_q   <= 1'b0;
            s1_com_q  <= '0;
            seg_d_q   <= '0;
            seg_com_q <= '0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            bcnt_q    <= bcnt_d;
            sh_bcd_q  <= sh_bcd_d;
            sh_dp_q   <= sh_dp_d;
            sh_bl_q   <= sh_bl_d;
            fd_q      <= fd_d;
            s1_nib_q  <= s1_nib_d;
            s1_dp_q   <= s1_dp_d;
            s1_lz_q   <= s1_lz_d;
            s1_bk_q   <= s1_bk_d;
            s1_com_q  <= s1_com_d;
            seg_d_q   <= seg_d_d;
            seg_com_q <= seg_com_d;
        end
    end

    assign seg_d      = seg_d_q;
    assign seg_com    = seg_com_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctl.sv
// Bench for seg_scan_ctl: directed literal checks plus randomized traffic against a cycle-count model.
module tb_seg_scan_ctl;
    localparam int ND = 8;
    localparam int PW = 16;
    localparam int BL = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      rate;
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   dp_mask, blink_mask;
    logic            blank_lz, hex_mode;
    logic [3:0]      bright;
    logic [7:0]      seg_d;
    logic [ND-1:0]   seg_com;
    logic            frame_done;

    seg_scan_ctl #(.NDIG(ND), .PRESC_W(PW), .BLINK_LOG2(BL)) dut (
        .clk(clk), .rst(rst), .rate(rate), .bcd(bcd), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .hex_mode(hex_mode),
        .bright(bright), .seg_d(seg_d), .seg_com(seg_com), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // What the display sees in one cycle: the digit being scanned, the frame's
    // captured data, the blink phase and the live controls.
    typedef struct {
        int              dig;
        logic [4*ND-1:0] sb;
        logic [ND-1:0]   sdp;
        logic [ND-1:0]   sbl;
        bit              bph;
        bit              blz;
        bit              hex;
        logic [3:0]      br;
        int              pwm;
    } rec_t;

    rec_t            hist[$];
    int              n;
    int              m_dig, m_frames;
    logic [4*ND-1:0] m_sb;
    logic [ND-1:0]   m_sdp, m_sbl;
    bit              m_fd;

    function automatic logic [6:0] glyph_of(input logic [3:0] v, input bit hx);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h27;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
        endcase
        if (v > 4'h9 && !hx) g = 7'h00;
        return g;
    endfunction

    task automatic compare();
        rec_t a, b;
        logic [7:0]    exp_d;
        logic [ND-1:0] exp_com, one;
        bit            lz, bk;
        if (n >= 2) begin
            a   = hist[0];
            b   = hist[1];
            one = 1;
            lz  = a.blz && a.dig != 0 && ((a.sb >> (4 * a.dig)) == 0);
            bk  = a.bph && a.sbl[a.dig];
            exp_d   = bk ? 8'h00 : {a.sdp[a.dig], (lz ? 7'h00 : glyph_of(a.sb[4*a.dig +: 4], b.hex))};
            exp_com = (b.pwm <= int'(b.br)) ? (one << a.dig) : '0;
            chk("model_seg_d", seg_d, exp_d);
            chk("model_seg_com", seg_com, exp_com);
        end
        if (n >= 1) chk("model_frame_done", frame_done, m_fd);
    endtask

    task automatic record_advance();
        rec_t r;
        int   per;
        r.dig = m_dig; r.sb = m_sb; r.sdp = m_sdp; r.sbl = m_sbl;
        r.bph = ((m_frames >> BL) & 1) != 0;
        r.blz = blank_lz; r.hex = hex_mode; r.br = bright; r.pwm = n % 16;
        hist.push_back(r);
        if (hist.size() > 2) void'(hist.pop_front());
        per  = 1 << rate;
        m_fd = 1'b0;
        if ((n % per) == per - 1) begin
            if (m_dig == ND - 1) begin
                m_dig = 0;
                m_sb = bcd; m_sdp = dp_mask; m_sbl = blink_mask;
                m_frames++;
                m_fd = 1'b1;
            end else begin
                m_dig++;
            end
        end
        n++;
    endtask

    // Called at a falling edge; returns at a later falling edge with reset released.
    task automatic do_reset(input bit mid);
        if (mid) #2;
        rst = 1'b1;
        #1;
        chk("rst_seg_d", seg_d, 8'h00);
        chk("rst_seg_com", seg_com, '0);
        chk("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n = 0; m_dig = 0; m_frames = 0; m_sb = '0; m_sdp = '0; m_sbl = '0; m_fd = 1'b0;
        hist.delete();
    endtask

    int         epoch, r3, cnt_on;
    logic [7:0] d_hold;
    bit         reset_req;

    initial begin
        rate = 4'd0; bright = 4'd15; bcd = 32'h12345678; dp_mask = '0; blink_mask = '0;
        blank_lz = 1'b0; hex_mode = 1'b0;
        epoch = 1; r3 = 0; cnt_on = 0; d_hold = '0; reset_req = 1'b0;
        do_reset(1'b0);
        while (epoch != 4) begin
            compare();
            if (epoch == 1) begin
                case (n)
                    8, 16:  chk("scan_frame_done", frame_done, 1'b1);
                    10: begin chk("scan_d0_seg", seg_d, 8'h7F); chk("scan_d0_com", seg_com, 8'h01); end
                    17: begin chk("scan_d7_seg", seg_d, 8'h06); chk("scan_d7_com", seg_com, 8'h80); end
                    18: begin blank_lz = 1'b1; bcd = 32'h00000305; dp_mask = 8'h04; end
                    26: chk("lz_d0", seg_d, 8'h6D);
                    27: chk("lz_d1", seg_d, 8'h3F);
                    28: chk("lz_d2_dp", seg_d, 8'hCF);
                    30: chk("lz_d4_blank", seg_d, 8'h00);
                    32: begin bcd = 32'h0000000A; hex_mode = 1'b1; blank_lz = 1'b0; dp_mask = '0; end
                    42: chk("hex_on_A", seg_d, 8'h77);
                    44: hex_mode = 1'b0;
                    48: begin bcd = 32'h00000005; blink_mask = 8'h01; end
                    50: chk("hex_off_A", seg_d, 8'h00);
                    58: chk("blink_off_f7", seg_d, 8'h00);
                    59: chk("blink_other_digit", seg_d, 8'h3F);
                    66: chk("blink_on_f8", seg_d, 8'h6D);
                    74: chk("blink_on_f9", seg_d, 8'h6D);
                    82: chk("blink_off_f10", seg_d, 8'h00);
                    90: chk("blink_off_f11", seg_d, 8'h00);
                    98: chk("blink_on_f12", seg_d, 8'h6D);
                    102: begin
                        chk("pre_reset_d4_com", seg_com, 8'h10);
                        rate = 4'd5; bright = 4'd3; bcd = '0; blink_mask = '0;
                        reset_req = 1'b1; epoch = 2;
                    end
                    default: ;
                endcase
            end else if (epoch == 2) begin
                if (n == 66) begin d_hold = seg_d; chk("pwm_slot_glyph", seg_d, 8'h3F); end
                if (n >= 66 && n <= 97 && seg_com != 0) cnt_on++;
                if (n == 97) begin
                    chk("pwm_on_count", cnt_on, 8);
                    chk("pwm_seg_d_steady", seg_d, d_hold);
                end
                if (n == 255) chk("first_fd_not_early", frame_done, 1'b0);
                if (n == 256) chk("first_fd_after_ndig_ticks", frame_done, 1'b1);
                if (n == 260) epoch = 3;
            end else begin
                r3++;
                if ($urandom_range(0, 39) == 0) rate = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) bcd = $urandom >> (4 * $urandom_range(0, 8));
                if ($urandom_range(0, 9) == 0) begin
                    dp_mask = 8'($urandom); blink_mask = 8'($urandom);
                end
                if ($urandom_range(0, 19) == 0) begin
                    blank_lz = 1'($urandom); hex_mode = 1'($urandom); bright = 4'($urandom);
                end
                if (r3 == 1500) reset_req = 1'b1;
                if (r3 == 3000) epoch = 4;
            end
            if (reset_req) begin
                reset_req = 1'b0;
                do_reset(1'b1);
                continue;
            end
            record_advance();
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
